// File: rtl/qeip_sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : qeip_sram_access_scheduler
// Purpose  : Round-robin scheduler of two single-beat requesters onto one AXI
//            SRAM slave port, one transaction outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module qeip_sram_access_scheduler #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 4
) (
    input  logic                    clk,
    input  logic                    rstpp,

    input  logic                    r0_reqvalid,
    output logic                    r0_reqready,
    input  logic                    r0_reqwrite,
    input  logic [BW_ADDR-1:0]      r0_reqaddr,
    input  logic [BW_DATA-1:0]      r0_reqwdata,
    input  logic [BW_DATA/8-1:0]    r0_reqwstrb,
    output logic                    r0_rspvalid,
    output logic [BW_DATA-1:0]      r0_rsprdata,
    output logic [1:0]              r0_rspresp,

    input  logic                    r1_reqvalid,
    output logic                    r1_reqready,
    input  logic                    r1_reqwrite,
    input  logic [BW_ADDR-1:0]      r1_reqaddr,
    input  logic [BW_DATA-1:0]      r1_reqwdata,
    input  logic [BW_DATA/8-1:0]    r1_reqwstrb,
    output logic                    r1_rspvalid,
    output logic [BW_DATA-1:0]      r1_rsprdata,
    output logic [1:0]              r1_rspresp,

    output logic                    busy,

    output logic                    sxawvalid,
    output logic [BW_ADDR-1:0]      sxawaddr,
    output logic [BW_AXI_TID-1:0]   sxawid,
    output logic [7:0]              sxawlen,
    output logic [2:0]              sxawsize,
    output logic [1:0]              sxawburst,
    input  logic                    sxawready,

    output logic                    sxwvalid,
    output logic [BW_AXI_TID-1:0]   sxwid,
    output logic [BW_DATA-1:0]      sxwdata,
    output logic [BW_DATA/8-1:0]    sxwstrb,
    output logic                    sxwlast,
    input  logic                    sxwready,

    input  logic                    sxbvalid,
    input  logic [BW_AXI_TID-1:0]   sxbid,
    input  logic [1:0]              sxbresp,
    output logic                    sxbready,

    output logic                    sxarvalid,
    output logic [BW_ADDR-1:0]      sxaraddr,
    output logic [BW_AXI_TID-1:0]   sxarid,
    output logic [7:0]              sxarlen,
    output logic [2:0]              sxarsize,
    output logic [1:0]              sxarburst,
    input  logic                    sxarready,

    input  logic                    sxrvalid,
    input  logic [BW_AXI_TID-1:0]   sxrid,
    input  logic [BW_DATA-1:0]      sxrdata,
    input  logic                    sxrlast,
    input  logic [1:0]              sxrresp,
    output logic                    sxrready
);

    localparam int         BW_STRB = BW_DATA / 8;
    localparam logic [2:0] C_SIZE  = 3'($clog2(BW_STRB));

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WREQ = 3'd1,
        WRSP = 3'd2,
        RREQ = 3'd3,
        RRSP = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;
    logic                 owner_q, owner_d;
    logic [BW_ADDR-1:0]   addr_q, addr_d;
    logic [BW_DATA-1:0]   wdata_q, wdata_d;
    logic [BW_STRB-1:0]   wstrb_q, wstrb_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 arvalid_q, arvalid_d;
    logic                 bready_q, bready_d;
    logic                 rready_q, rready_d;
    logic                 rsp0valid_q, rsp0valid_d;
    logic [BW_DATA-1:0]   rsp0rdata_q, rsp0rdata_d;
    logic [1:0]           rsp0resp_q, rsp0resp_d;
    logic                 rsp1valid_q, rsp1valid_d;
    logic [BW_DATA-1:0]   rsp1rdata_q, rsp1rdata_d;
    logic [1:0]           rsp1resp_q, rsp1resp_d;

    logic                 idle;
    logic                 accept;
    logic                 sel_write;
    logic [BW_ADDR-1:0]   sel_addr;
    logic [BW_DATA-1:0]   sel_wdata;
    logic [BW_STRB-1:0]   sel_wstrb;
    logic                 w_unused;

    // A lone requester always wins; on contention prio_q names the winner.
    assign idle        = (state_q == IDLE);
    assign r0_reqready = idle && r0_reqvalid && !(r1_reqvalid && prio_q);
    assign r1_reqready = idle && r1_reqvalid && !(r0_reqvalid && !prio_q);
    assign accept      = r0_reqready || r1_reqready;
    assign busy        = !idle;

    assign sel_write = r1_reqready ? r1_reqwrite : r0_reqwrite;
    assign sel_addr  = r1_reqready ? r1_reqaddr  : r0_reqaddr;
    assign sel_wdata = r1_reqready ? r1_reqwdata : r0_reqwdata;
    assign sel_wstrb = r1_reqready ? r1_reqwstrb : r0_reqwstrb;

    assign w_unused = ^{sxbid, sxrid};

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp0valid_d = 1'b0;
        rsp0rdata_d = rsp0rdata_q;
        rsp0resp_d  = rsp0resp_q;
        rsp1valid_d = 1'b0;
        rsp1rdata_d = rsp1rdata_q;
        rsp1resp_d  = rsp1resp_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d = r1_reqready;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wstrb_d = sel_wstrb;
                    if (sel_write) begin
                        state_d   = WREQ;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RREQ;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WREQ: begin
                if (sxawready) awvalid_d = 1'b0;
                if (sxwready)  wvalid_d  = 1'b0;
                // Leave once both channels have handshaken, in either order.
                if ((!awvalid_q || sxawready) && (!wvalid_q || sxwready)) begin
                    state_d  = WRSP;
                    bready_d = 1'b1;
                end
            end
            WRSP: begin
                if (sxbvalid && bready_q) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    prio_d   = !owner_q;
                    if (owner_q) begin
                        rsp1valid_d = 1'b1;
                        rsp1rdata_d = '0;
                        rsp1resp_d  = sxbresp;
                    end else begin
                        rsp0valid_d = 1'b1;
                        rsp0rdata_d = '0;
                        rsp0resp_d  = sxbresp;
                    end
                end
            end
            RREQ: begin
                if (sxarready) begin
                    state_d   = RRSP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RRSP: begin
                // Non-last beats are consumed and discarded.
                if (sxrvalid && sxrlast && rready_q) begin
                    state_d  = IDLE;
                    rready_d = 1'b0;
                    prio_d   = !owner_q;
                    if (owner_q) begin
                        rsp1valid_d = 1'b1;
                        rsp1rdata_d = sxrdata;
                        rsp1resp_d  = sxrresp;
                    end else begin
                        rsp0valid_d = 1'b1;
                        rsp0rdata_d = sxrdata;
                        rsp0resp_d  = sxrresp;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp0valid_q <= 1'b0;
            rsp0rdata_q <= '0;
            rsp0resp_q  <= '0;
            rsp1valid_q <= 1'b0;
            rsp1rdata_q <= '0;
            rsp1resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp0valid_q <= rsp0valid_d;
            rsp0rdata_q <= rsp0rdata_d;
            rsp0resp_q  <= rsp0resp_d;
            rsp1valid_q <= rsp1valid_d;
            rsp1rdata_q <= rsp1rdata_d;
            rsp1resp_q  <= rsp1resp_d;
        end
    end

    assign sxawvalid = awvalid_q;
    assign sxawaddr  = addr_q;
    assign sxawid    = BW_AXI_TID'(owner_q);
    assign sxawlen   = 8'd0;
    assign sxawsize  = C_SIZE;
    assign sxawburst = 2'b01;

    assign sxwvalid  = wvalid_q;
    assign sxwid     = BW_AXI_TID'(owner_q);
    assign sxwdata   = wdata_q;
    assign sxwstrb   = wstrb_q;
    assign sxwlast   = 1'b1;

    assign sxbready  = bready_q;

    assign sxarvalid = arvalid_q;
    assign sxaraddr  = addr_q;
    assign sxarid    = BW_AXI_TID'(owner_q);
    assign sxarlen   = 8'd0;
    assign sxarsize  = C_SIZE;
    assign sxarburst = 2'b01;

    assign sxrready  = rready_q;

    assign r0_rspvalid = rsp0valid_q;
    assign r0_rsprdata = rsp0rdata_q;
    assign r0_rspresp  = rsp0resp_q;
    assign r1_rspvalid = rsp1valid_q;
    assign r1_rsprdata = rsp1rdata_q;
    assign r1_rspresp  = rsp1resp_q;

endmodule
`default_nettype wire

// File: tb/tb_qeip_sram_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_qeip_sram_access_scheduler
// Purpose  : Randomised bench with an SRAM slave model and a transaction-level
//            reference (round-robin grant, byte-strobed memory, latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_qeip_sram_access_scheduler;

    logic        clk = 1'b0;
    logic        rstpp;
    logic        r0_reqvalid, r0_reqready, r0_reqwrite, r0_rspvalid;
    logic [31:0] r0_reqaddr, r0_reqwdata, r0_rsprdata;
    logic [3:0]  r0_reqwstrb;
    logic [1:0]  r0_rspresp;
    logic        r1_reqvalid, r1_reqready, r1_reqwrite, r1_rspvalid;
    logic [31:0] r1_reqaddr, r1_reqwdata, r1_rsprdata;
    logic [3:0]  r1_reqwstrb;
    logic [1:0]  r1_rspresp;
    logic        busy;
    logic        sxawvalid, sxawready, sxwvalid, sxwready, sxwlast;
    logic        sxbvalid, sxbready, sxarvalid, sxarready;
    logic        sxrvalid, sxrready, sxrlast;
    logic [31:0] sxawaddr, sxaraddr, sxwdata, sxrdata;
    logic [3:0]  sxawid, sxwid, sxarid, sxbid, sxrid, sxwstrb;
    logic [7:0]  sxawlen, sxarlen;
    logic [2:0]  sxawsize, sxarsize;
    logic [1:0]  sxawburst, sxarburst, sxbresp, sxrresp;

    qeip_sram_access_scheduler #(.BW_ADDR(32), .BW_DATA(32), .BW_AXI_TID(4)) dut (
        .clk(clk), .rstpp(rstpp),
        .r0_reqvalid(r0_reqvalid), .r0_reqready(r0_reqready), .r0_reqwrite(r0_reqwrite),
        .r0_reqaddr(r0_reqaddr), .r0_reqwdata(r0_reqwdata), .r0_reqwstrb(r0_reqwstrb),
        .r0_rspvalid(r0_rspvalid), .r0_rsprdata(r0_rsprdata), .r0_rspresp(r0_rspresp),
        .r1_reqvalid(r1_reqvalid), .r1_reqready(r1_reqready), .r1_reqwrite(r1_reqwrite),
        .r1_reqaddr(r1_reqaddr), .r1_reqwdata(r1_reqwdata), .r1_reqwstrb(r1_reqwstrb),
        .r1_rspvalid(r1_rspvalid), .r1_rsprdata(r1_rsprdata), .r1_rspresp(r1_rspresp),
        .busy(busy),
        .sxawvalid(sxawvalid), .sxawaddr(sxawaddr), .sxawid(sxawid), .sxawlen(sxawlen),
        .sxawsize(sxawsize), .sxawburst(sxawburst), .sxawready(sxawready),
        .sxwvalid(sxwvalid), .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb),
        .sxwlast(sxwlast), .sxwready(sxwready),
        .sxbvalid(sxbvalid), .sxbid(sxbid), .sxbresp(sxbresp), .sxbready(sxbready),
        .sxarvalid(sxarvalid), .sxaraddr(sxaraddr), .sxarid(sxarid), .sxarlen(sxarlen),
        .sxarsize(sxarsize), .sxarburst(sxarburst), .sxarready(sxarready),
        .sxrvalid(sxrvalid), .sxrid(sxrid), .sxrdata(sxrdata), .sxrlast(sxrlast),
        .sxrresp(sxrresp), .sxrready(sxrready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // ---------------- SRAM slave model ----------------
    bit          rand_mode = 0;
    int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    bit          r_extra = 0, r_force = 0;
    logic [31:0] r_force_data = '0;
    logic [1:0]  r_force_resp = '0;
    logic [31:0] smem [logic [31:0]];
    bit          s_got_aw, s_got_w, s_pend_b, s_pend_r, s_r_first;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    int          aw_cnt, w_cnt, b_cnt, r_cnt, aw_cur, w_cur, b_cur, r_cur;

    always begin : sram_model
        @(negedge clk);
        if (rstpp) begin
            s_got_aw = 0; s_got_w = 0; s_pend_b = 0; s_pend_r = 0;
        end else begin
            if (sxawvalid && sxawready) begin s_got_aw = 1; s_awaddr = sxawaddr; end
            if (sxwvalid && sxwready) begin s_got_w = 1; s_wdata = sxwdata; s_wstrb = sxwstrb; end
            if (s_got_aw && s_got_w) begin
                smem[s_awaddr] = merge(smem.exists(s_awaddr) ? smem[s_awaddr] : 32'h0,
                                       s_wdata, s_wstrb);
                s_got_aw = 0; s_got_w = 0; s_pend_b = 1; b_cnt = 0;
                b_cur   = rand_mode ? int'($urandom_range(0, 2)) : b_delay;
                s_bresp = rand_mode ? 2'($urandom_range(0, 3)) : 2'b00;
            end
            if (sxbvalid && sxbready) s_pend_b = 0;
            if (sxrvalid && sxrready) begin
                if (sxrlast) s_pend_r = 0;
                else         s_r_first = 1;
            end
            if (sxarvalid && sxarready) begin
                s_pend_r = 1; s_araddr = sxaraddr; r_cnt = 0; s_r_first = 0;
                r_cur   = rand_mode ? int'($urandom_range(0, 2)) : r_delay;
                s_rresp = rand_mode ? 2'($urandom_range(0, 3)) : 2'b00;
            end
        end
        @(posedge clk);
        #1;
        if (rstpp) begin
            sxawready = 0; sxwready = 0; sxbvalid = 0; sxarready = 0; sxrvalid = 0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            if (sxawvalid && !s_got_aw) begin
                if (aw_cnt == 0) aw_cur = rand_mode ? int'($urandom_range(0, 2)) : aw_delay;
                sxawready = (aw_cnt >= aw_cur);
                aw_cnt++;
            end else begin
                sxawready = 0; aw_cnt = 0;
            end
            if (sxwvalid && !s_got_w) begin
                if (w_cnt == 0) w_cur = rand_mode ? int'($urandom_range(0, 2)) : w_delay;
                sxwready = (w_cnt >= w_cur);
                w_cnt++;
            end else begin
                sxwready = 0; w_cnt = 0;
            end
            sxarready = sxarvalid;
            if (s_pend_b) begin
                sxbvalid = (b_cnt >= b_cur); b_cnt++;
                sxbresp  = s_bresp; sxbid = 4'($urandom);
            end else sxbvalid = 0;
            if (s_pend_r) begin
                sxrvalid = (r_cnt >= r_cur); r_cnt++;
                sxrid    = 4'($urandom);
                if (r_extra && !s_r_first) begin
                    sxrlast = 0; sxrdata = 32'hDEAD; sxrresp = 2'b00;
                end else begin
                    sxrlast = 1;
                    sxrdata = r_force ? r_force_data
                                      : (smem.exists(s_araddr) ? smem[s_araddr] : 32'h0);
                    sxrresp = r_force ? r_force_resp : s_rresp;
                end
            end else sxrvalid = 0;
        end
    end

    // ---------------- transaction-level reference / monitor ----------------
    bit          cur_active = 0, cur_wr, cur_zero, aw_done, tb_prio = 0;
    int          cur_owner, acc_cyc, bhs_cyc, rhs_cyc;
    logic [31:0] cur_addr, cur_wdata, cur_exp_rdata;
    logic [3:0]  cur_wstrb;
    logic [1:0]  cur_exp_resp;
    int          aw_vcyc, w_vcyc, busy_low, bready_early;
    int          last_aw_vcyc, last_w_vcyc;
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] last_rd [2];
    logic [1:0]  last_rs [2];
    int          n_rsp = 0, n_acc = 0, n_abort = 0;
    int          grant_q[$];

    always begin : monitor
        logic [31:0] o_rd, x_rd;
        logic [1:0]  o_rs, x_rs;
        int          g, exp_g;
        @(negedge clk);
        if (rstpp) begin
            if (cur_active) n_abort++;
            cur_active = 0; tb_prio = 0;
            last_rd[0] = '0; last_rd[1] = '0; last_rs[0] = '0; last_rs[1] = '0;
        end else begin
            if (r0_rspvalid || r1_rspvalid) begin
                if (!cur_active) check("rsp_unexpected", 64'(1), 64'(0));
                else begin
                    check("rsp_owner", 64'({r1_rspvalid, r0_rspvalid}),
                          64'(cur_owner == 1 ? 2'b10 : 2'b01));
                    o_rd = cur_owner == 1 ? r1_rsprdata : r0_rsprdata;
                    o_rs = cur_owner == 1 ? r1_rspresp  : r0_rspresp;
                    x_rd = cur_owner == 1 ? r0_rsprdata : r1_rsprdata;
                    x_rs = cur_owner == 1 ? r0_rspresp  : r1_rspresp;
                    check("rsp_rdata", 64'(o_rd), 64'(cur_wr ? 32'h0 : cur_exp_rdata));
                    check("rsp_resp", 64'(o_rs), 64'(cur_exp_resp));
                    check("rsp_timing", 64'(cyc), 64'((cur_wr ? bhs_cyc : rhs_cyc) + 1));
                    check("nonowner_rdata", 64'(x_rd), 64'(last_rd[1 - cur_owner]));
                    check("nonowner_resp", 64'(x_rs), 64'(last_rs[1 - cur_owner]));
                    if (cur_zero) check("latency", 64'(cyc - acc_cyc), 64'(3));
                    check("busy_in_txn", 64'(busy_low), 64'(0));
                    if (cur_wr) check("wrsp_before_aw", 64'(bready_early), 64'(0));
                    last_rd[cur_owner] = o_rd; last_rs[cur_owner] = o_rs;
                    last_aw_vcyc = aw_vcyc; last_w_vcyc = w_vcyc;
                    tb_prio = (cur_owner == 0);
                    n_rsp++;
                    cur_active = 0;
                end
            end
            if (cur_active) begin
                if (!busy) busy_low++;
                if (sxawvalid) aw_vcyc++;
                if (sxwvalid) w_vcyc++;
                if (sxbready && !aw_done) bready_early++;
                if (sxawvalid && sxawready) begin
                    check("aw_addr", 64'(sxawaddr), 64'(cur_addr));
                    check("aw_id", 64'(sxawid), 64'(cur_owner));
                    check("aw_len", 64'(sxawlen), 64'(0));
                    check("aw_size", 64'(sxawsize), 64'(2));
                    check("aw_burst", 64'(sxawburst), 64'(1));
                    if (cur_zero) check("aw_cycle", 64'(cyc - acc_cyc), 64'(1));
                    aw_done = 1;
                end
                if (sxwvalid && sxwready) begin
                    check("w_data", 64'(sxwdata), 64'(cur_wdata));
                    check("w_strb", 64'(sxwstrb), 64'(cur_wstrb));
                    check("w_last", 64'(sxwlast), 64'(1));
                    check("w_id", 64'(sxwid), 64'(cur_owner));
                end
                if (sxbvalid && sxbready) begin bhs_cyc = cyc; cur_exp_resp = sxbresp; end
                if (sxarvalid && sxarready) begin
                    check("ar_addr", 64'(sxaraddr), 64'(cur_addr));
                    check("ar_id", 64'(sxarid), 64'(cur_owner));
                    check("ar_len", 64'(sxarlen), 64'(0));
                    check("ar_size", 64'(sxarsize), 64'(2));
                    check("ar_burst", 64'(sxarburst), 64'(1));
                    if (cur_zero) check("ar_cycle", 64'(cyc - acc_cyc), 64'(1));
                end
                if (sxrvalid && sxrready && sxrlast) begin rhs_cyc = cyc; cur_exp_resp = sxrresp; end
            end
            if (r0_reqready || r1_reqready) begin
                check("single_grant", 64'(r0_reqready && r1_reqready), 64'(0));
                check("grant_when_idle", 64'(cur_active), 64'(0));
                exp_g = (r0_reqvalid && r1_reqvalid) ? int'(tb_prio) : int'(r1_reqvalid);
                g = r1_reqready ? 1 : 0;
                check("grant_rr", 64'(g), 64'(exp_g));
                cur_owner = g;
                cur_wr    = g ? r1_reqwrite : r0_reqwrite;
                cur_addr  = g ? r1_reqaddr  : r0_reqaddr;
                cur_wdata = g ? r1_reqwdata : r0_reqwdata;
                cur_wstrb = g ? r1_reqwstrb : r0_reqwstrb;
                if (cur_wr)
                    rmem[cur_addr] = merge(rmem.exists(cur_addr) ? rmem[cur_addr] : 32'h0,
                                           cur_wdata, cur_wstrb);
                else
                    cur_exp_rdata = r_force ? r_force_data
                                            : (rmem.exists(cur_addr) ? rmem[cur_addr] : 32'h0);
                cur_zero = !rand_mode && aw_delay == 0 && w_delay == 0 && b_delay == 0 &&
                           r_delay == 0 && !r_extra;
                aw_vcyc = 0; w_vcyc = 0; busy_low = 0; bready_early = 0; aw_done = 0;
                acc_cyc = cyc; cur_active = 1; n_acc++;
                grant_q.push_back(g);
            end else if (!cur_active && (r0_reqvalid || r1_reqvalid)) begin
                check("grant_missing", 64'(0), 64'(1));
            end
        end
    end

    // ---------------- requester drivers ----------------
    task automatic req(input int who, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        bit got;
        got = 0;
        if (who == 0) begin
            r0_reqwrite = wr; r0_reqaddr = a; r0_reqwdata = d; r0_reqwstrb = s; r0_reqvalid = 1;
        end else begin
            r1_reqwrite = wr; r1_reqaddr = a; r1_reqwdata = d; r1_reqwstrb = s; r1_reqvalid = 1;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if ((who == 0 && r0_reqready) || (who == 1 && r1_reqready)) begin
                got = 1;
                break;
            end
        end
        if (!got) check("req_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        if (who == 0) r0_reqvalid = 0; else r1_reqvalid = 0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (!cur_active) break;
        end
        if (cur_active) check("idle_timeout", 64'(1), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_thread(input int who, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            req(who, 1'($urandom), 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom,
                4'($urandom));
        end
    endtask

    initial begin
        int n0;
        bit seen;
        rstpp = 1;
        r0_reqvalid = 0; r0_reqwrite = 0; r0_reqaddr = 0; r0_reqwdata = 0; r0_reqwstrb = 0;
        r1_reqvalid = 0; r1_reqwrite = 0; r1_reqaddr = 0; r1_reqwdata = 0; r1_reqwstrb = 0;
        sxawready = 0; sxwready = 0; sxbvalid = 0; sxbid = 0; sxbresp = 0; sxarready = 0;
        sxrvalid = 0; sxrid = 0; sxrdata = 0; sxrlast = 0; sxrresp = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({sxawvalid, sxwvalid, sxarvalid, sxbready, sxrready,
                                    r0_rspvalid, r1_rspvalid, busy}), 64'(0));
        check("reset_rsp_fields", 64'({r0_rsprdata, r0_rspresp, r1_rspresp}), 64'(0));
        rstpp = 0;
        @(posedge clk);
        #1;

        // write then read back, zero-wait
        req(0, 1, 32'h10, 32'hA5A5_0001, 4'hF);
        wait_idle();
        check("t1_resp", 64'(last_rs[0]), 64'(0));
        req(1, 0, 32'h10, 32'h0, 4'h0);
        wait_idle();
        check("t2_rdata", 64'(last_rd[1]), 64'hA5A5_0001);
        check("t2_rsp_count", 64'(n_rsp), 64'(2));

        // both requesters continuously valid
        grant_q.delete();
        fork
            begin
                for (int i = 0; i < 2; i++)
                    req(0, (i % 2) == 0, 32'h20 + 32'(8 * i), 32'h1111_0000 + 32'(i), 4'hF);
            end
            begin
                for (int i = 0; i < 2; i++)
                    req(1, (i % 2) == 1, 32'h24 + 32'(8 * i), 32'h2222_0000 + 32'(i), 4'hF);
            end
        join
        wait_idle();
        check("rr_count", 64'(grant_q.size()), 64'(4));
        for (int i = 0; i < 4; i++)
            if (i < grant_q.size()) check("rr_order", 64'(grant_q[i]), 64'(i % 2));

        // AW accepted late, W immediately
        aw_delay = 2;
        req(0, 1, 32'h30, 32'h1234_5678, 4'h3);
        wait_idle();
        check("aw_held_cycles", 64'(last_aw_vcyc), 64'(3));
        check("w_held_cycles", 64'(last_w_vcyc), 64'(1));
        aw_delay = 0;

        // read with a discarded non-last beat
        r_extra = 1; r_force = 1; r_force_data = 32'hBEEF; r_force_resp = 2'd2;
        n0 = n_rsp;
        req(0, 0, 32'h30, 32'h0, 4'h0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("extra_beat_rsp_count", 64'(n_rsp - n0), 64'(1));
        check("extra_beat_rdata", 64'(last_rd[0]), 64'hBEEF);
        check("extra_beat_resp", 64'(last_rs[0]), 64'(2));
        r_extra = 0; r_force = 0;

        // reset pulse while waiting for B
        b_delay = 6;
        req(1, 1, 32'h40, 32'hCAFE_F00D, 4'hF);
        seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (sxbready) begin seen = 1; break; end
        end
        check("reach_wrsp", 64'(seen), 64'(1));
        @(posedge clk);
        #2;
        rstpp = 1;
        #1;
        check("async_reset_outputs", 64'({sxawvalid, sxwvalid, sxarvalid, sxbready, sxrready,
                                          r0_rspvalid, r1_rspvalid, busy}), 64'(0));
        check("async_reset_rdata", 64'({r0_rsprdata, r1_rsprdata}), 64'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rstpp = 0;
        b_delay = 0;
        n0 = n_rsp;
        repeat (8) @(posedge clk);
        #1;
        check("no_rsp_after_abort", 64'(n_rsp), 64'(n0));
        grant_q.delete();
        fork
            req(0, 0, 32'h40, 32'h0, 4'h0);
            req(1, 0, 32'h10, 32'h0, 4'h0);
        join
        wait_idle();
        if (grant_q.size() > 0) check("prio_after_reset", 64'(grant_q[0]), 64'(0));
        else check("prio_after_reset", 64'(1), 64'(0));
        grant_q.delete();
        req(1, 0, 32'h40, 32'h0, 4'h0);
        wait_idle();
        check("r1_only_after_reset", 64'(grant_q.size() == 1 && grant_q[0] == 1), 64'(1));

        // randomised traffic with random SRAM waits and responses
        rand_mode = 1;
        fork
            rand_thread(0, 15);
            rand_thread(1, 15);
        join
        wait_idle();
        rand_mode = 0;
        check("rsp_vs_accept", 64'(n_rsp), 64'(n_acc - n_abort));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion required $finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
